rect_fill_engine: RTL and testbench

- Graphics write engine that fills an axis-aligned rectangle of one colour in a DDR2 framebuffer.
- Sits upstream of the DDR2 request controller on a dedicated write port, the same af/wdf port style as the frame filler and line engine.
- The graphics command processor issues one rectangle at a time.
- Emits one write command plus two 128-bit write-data beats per 8-pixel burst, with byte masks for partial bursts at the left and right edges.

---
 rtl/gfx_pkg.sv | 28 ++
 rtl/rect_fill_engine_if.sv | 43 ++++
 rtl/rect_edge_mask.sv | 28 ++
 rtl/rect_fill_engine.sv | 171 +++++++++++++++++
 tb/tb_rect_fill_engine.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/gfx_pkg.sv
// -----------------------------------------------------------------------------
// gfx_pkg
// Definitions shared by the graphics write engines (rectangle fill, line
// engine, pixel feeder): DDR2 address-FIFO command codes, default framebuffer
// geometry, the framebuffer burst-address builder and the fill FSM state type.
// -----------------------------------------------------------------------------
package gfx_pkg;

    localparam logic [2:0] AF_CMD_WRITE = 3'b000;
    localparam logic [2:0] AF_CMD_READ  = 3'b001;

    localparam int FB_WIDTH_DEF  = 800;
    localparam int FB_HEIGHT_DEF = 600;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATB = 2'd2
    } fill_state_e;

    // Burst address: 1 MiB-aligned base, 1024-pixel row stride, 8-pixel bursts.
    function automatic logic [30:0] fb_addr(input logic [10:0] base,
                                            input logic [9:0]  y,
                                            input logic [6:0]  bx);
        return {base, y, bx, 3'b000};
    endfunction

endpackage

// File: rtl/rect_fill_engine_if.sv
// -----------------------------------------------------------------------------
// rect_fill_engine_if
// Bundles the rectangle command port and the DDR2 af/wdf write port.
//   Command : valid, x0, y0, x1, y1, color, frame_base -> engine; ready <- engine
//   FIFO    : af_full, wdf_full -> engine;
//             af_wr_en, af_cmd_din, af_addr_din,
//             wdf_wr_en, wdf_din, wdf_mask_din <- engine
// modport master : the fill engine (drives the FIFO write port)
// modport slave  : command processor / FIFO side
// -----------------------------------------------------------------------------
interface rect_fill_engine_if;

    logic         valid;
    logic [9:0]   x0;
    logic [9:0]   y0;
    logic [9:0]   x1;
    logic [9:0]   y1;
    logic [23:0]  color;
    logic [31:0]  frame_base;
    logic         ready;

    logic         af_full;
    logic         wdf_full;
    logic         af_wr_en;
    logic [2:0]   af_cmd_din;
    logic [30:0]  af_addr_din;
    logic         wdf_wr_en;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;

    modport master (
        input  valid, x0, y0, x1, y1, color, frame_base, af_full, wdf_full,
        output ready, af_wr_en, af_cmd_din, af_addr_din,
               wdf_wr_en, wdf_din, wdf_mask_din
    );

    modport slave (
        output valid, x0, y0, x1, y1, color, frame_base, af_full, wdf_full,
        input  ready, af_wr_en, af_cmd_din, af_addr_din,
               wdf_wr_en, wdf_din, wdf_mask_din
    );

endinterface

// File: rtl/rect_edge_mask.sv
// -----------------------------------------------------------------------------
// rect_edge_mask
// Combinational byte mask for one 4-pixel write beat.
//   bx_i     : burst column (8 pixels per burst)
//   beat_b_i : 0 = columns 8bx+0..3, 1 = columns 8bx+4..7
//   xl_i/xr_i: inclusive left/right rectangle edges
//   mask_o   : 4 bits per pixel, 1 = byte not written (outside [xl, xr])
// -----------------------------------------------------------------------------
module rect_edge_mask (
    input  logic [6:0]  bx_i,
    input  logic        beat_b_i,
    input  logic [9:0]  xl_i,
    input  logic [9:0]  xr_i,
    output logic [15:0] mask_o
);

    logic [9:0] col;

    always_comb begin
        mask_o = '0;
        col    = '0;
        for (int p = 0; p < 4; p++) begin
            col = {bx_i, beat_b_i, 2'(p)};
            mask_o[4*p +: 4] = ((col < xl_i) || (col > xr_i)) ? 4'hF : 4'h0;
        end
    end

endmodule

// File: rtl/rect_fill_engine.sv
// -----------------------------------------------------------------------------
// rect_fill_engine
// Fills an axis-aligned rectangle of one colour in the DDR2 framebuffer.
// Each 8-pixel burst is one af write command plus two 128-bit wdf beats;
// partial bursts at the left/right edges carry byte masks.
//   clk : core clock
//   rst : asynchronous, active-high reset
//   bus : rect_fill_engine_if.master (command port + af/wdf write port)
// -----------------------------------------------------------------------------
module rect_fill_engine
    import gfx_pkg::*;
#(
    parameter int FB_WIDTH  = FB_WIDTH_DEF,
    parameter int FB_HEIGHT = FB_HEIGHT_DEF,
    parameter int ROW_SHIFT = 10
) (
    input logic                clk,
    input logic                rst,
    rect_fill_engine_if.master bus
);

    // The address layout hard-wires a 1024-pixel row stride.
    if (ROW_SHIFT != 10) begin : g_bad_row_shift
        $error("rect_fill_engine: only ROW_SHIFT=10 is supported");
    end

    localparam logic [9:0] X_MAX = 10'(FB_WIDTH - 1);
    localparam logic [9:0] Y_MAX = 10'(FB_HEIGHT - 1);

    function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    fill_state_e  state_q, state_d;
    logic [9:0]   xl_q, xl_d, xr_q, xr_d, yt_q, yt_d, yb_q, yb_d;
    logic [9:0]   cy_q, cy_d;
    logic [6:0]   bx_q, bx_d;
    logic [23:0]  color_q, color_d;
    logic [10:0]  base_q, base_d;
    logic         af_wr_en_q, af_wr_en_d, wdf_wr_en_q, wdf_wr_en_d;
    logic [30:0]  af_addr_q, af_addr_d;
    logic [127:0] wdf_din_q, wdf_din_d;
    logic [15:0]  wdf_mask_q, wdf_mask_d;

    logic [9:0]   xl_c, xr_c, yt_c, yb_c;
    logic [15:0]  edge_mask;
    logic         unused_base_bits;

    // Only bits [30:20] of the base select the framebuffer.
    assign unused_base_bits = ^{bus.frame_base[31], bus.frame_base[19:0]};

    // Sorted, clamped corners of the incoming command.
    assign xl_c = clamp((bus.x0 < bus.x1) ? bus.x0 : bus.x1, X_MAX);
    assign xr_c = clamp((bus.x0 < bus.x1) ? bus.x1 : bus.x0, X_MAX);
    assign yt_c = clamp((bus.y0 < bus.y1) ? bus.y0 : bus.y1, Y_MAX);
    assign yb_c = clamp((bus.y0 < bus.y1) ? bus.y1 : bus.y0, Y_MAX);

    // In CMD the mask is for beat A, in DATB for beat B of the same burst.
    rect_edge_mask u_edge_mask (
        .bx_i     (bx_q),
        .beat_b_i (state_q == ST_DATB),
        .xl_i     (xl_q),
        .xr_i     (xr_q),
        .mask_o   (edge_mask)
    );

    always_comb begin
        state_d     = state_q;
        xl_d        = xl_q;
        xr_d        = xr_q;
        yt_d        = yt_q;
        yb_d        = yb_q;
        cy_d        = cy_q;
        bx_d        = bx_q;
        color_d     = color_q;
        base_d      = base_q;
        af_wr_en_d  = 1'b0;
        wdf_wr_en_d = 1'b0;
        af_addr_d   = af_addr_q;
        wdf_din_d   = wdf_din_q;
        wdf_mask_d  = wdf_mask_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.valid) begin
                    xl_d    = xl_c;
                    xr_d    = xr_c;
                    yt_d    = yt_c;
                    yb_d    = yb_c;
                    cy_d    = yt_c;
                    bx_d    = xl_c[9:3];
                    color_d = bus.color;
                    base_d  = bus.frame_base[30:20];
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                // Beat A must go out with its command, so both FIFOs need room.
                if (!bus.af_full && !bus.wdf_full) begin
                    af_wr_en_d  = 1'b1;
                    wdf_wr_en_d = 1'b1;
                    af_addr_d   = fb_addr(base_q, cy_q, bx_q);
                    wdf_din_d   = {4{8'h00, color_q}};
                    wdf_mask_d  = edge_mask;
                    state_d     = ST_DATB;
                end
            end
            ST_DATB: begin
                if (!bus.wdf_full) begin
                    wdf_wr_en_d = 1'b1;
                    wdf_din_d   = {4{8'h00, color_q}};
                    wdf_mask_d  = edge_mask;
                    if (bx_q < xr_q[9:3]) begin
                        bx_d    = bx_q + 7'd1;
                        state_d = ST_CMD;
                    end else if (cy_q < yb_q) begin
                        cy_d    = cy_q + 10'd1;
                        bx_d    = xl_q[9:3];
                        state_d = ST_CMD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            xl_q        <= '0;
            xr_q        <= '0;
            yt_q        <= '0;
            yb_q        <= '0;
            cy_q        <= '0;
            bx_q        <= '0;
            color_q     <= '0;
            base_q      <= '0;
            af_wr_en_q  <= 1'b0;
            wdf_wr_en_q <= 1'b0;
            af_addr_q   <= '0;
            wdf_din_q   <= '0;
            wdf_mask_q  <= 16'hFFFF;
        end else begin
            state_q     <= state_d;
            xl_q        <= xl_d;
            xr_q        <= xr_d;
            yt_q        <= yt_d;
            yb_q        <= yb_d;
            cy_q        <= cy_d;
            bx_q        <= bx_d;
            color_q     <= color_d;
            base_q      <= base_d;
            af_wr_en_q  <= af_wr_en_d;
            wdf_wr_en_q <= wdf_wr_en_d;
            af_addr_q   <= af_addr_d;
            wdf_din_q   <= wdf_din_d;
            wdf_mask_q  <= wdf_mask_d;
        end
    end

    assign bus.ready        = (state_q == ST_IDLE);
    assign bus.af_wr_en     = af_wr_en_q;
    assign bus.af_cmd_din   = AF_CMD_WRITE;
    assign bus.af_addr_din  = af_addr_q;
    assign bus.wdf_wr_en    = wdf_wr_en_q;
    assign bus.wdf_din      = wdf_din_q;
    assign bus.wdf_mask_din = wdf_mask_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// -----------------------------------------------------------------------------
// tb_rect_fill_engine
// Directed bench for rect_fill_engine: records every af/wdf push and compares
// against hand-computed burst addresses, masks and data.
// -----------------------------------------------------------------------------
module tb_rect_fill_engine;

    logic clk = 1'b0;
    logic rst;

    rect_fill_engine_if bus ();

    rect_fill_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic [30:0]  af_q[$];
    logic [15:0]  mk_q[$];
    logic [127:0] dt_q[$];
    logic         pa_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] px4(input logic [23:0] c);
        return {4{8'h00, c}};
    endfunction

    // FIFO-side recorder: a push is any cycle with the enable high.
    always @(negedge clk) begin
        if (bus.af_wr_en === 1'b1) af_q.push_back(bus.af_addr_din);
        if (bus.wdf_wr_en === 1'b1) begin
            mk_q.push_back(bus.wdf_mask_din);
            dt_q.push_back(bus.wdf_din);
            pa_q.push_back(bus.af_wr_en);
        end
    end

    task automatic clear_q();
        af_q.delete();
        mk_q.delete();
        dt_q.delete();
        pa_q.delete();
    endtask

    task automatic issue(input logic [9:0] ax0, input logic [9:0] ay0,
                         input logic [9:0] ax1, input logic [9:0] ay1,
                         input logic [23:0] c, input logic [31:0] fb);
        @(negedge clk);
        bus.x0 = ax0; bus.y0 = ay0; bus.x1 = ax1; bus.y1 = ay1;
        bus.color = c; bus.frame_base = fb;
        bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
    endtask

    // Counts negedges from the one after the capture cycle until ready.
    task automatic wait_idle(input string tag, output int n);
        n = 1;
        while (!bus.ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) chk({tag, "_timeout"}, bus.ready, 1'b1);
        #1;
    endtask

    task automatic exp_burst(input string tag, input int i, input logic [30:0] a,
                             input logic [15:0] ma, input logic [15:0] mb,
                             input logic [127:0] d);
        logic have;
        have = (af_q.size() > i) && (mk_q.size() > 2*i + 1);
        chk({tag, "_present"}, have, 1'b1);
        if (have) begin
            chk({tag, "_addr"},  af_q[i],       a);
            chk({tag, "_mskA"},  mk_q[2*i],     ma);
            chk({tag, "_mskB"},  mk_q[2*i+1],   mb);
            chk({tag, "_datA"},  dt_q[2*i],     d);
            chk({tag, "_datB"},  dt_q[2*i+1],   d);
            chk({tag, "_pairA"}, pa_q[2*i],     1'b1);
            chk({tag, "_pairB"}, pa_q[2*i+1],   1'b0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, bus.ready,        1'b1);
        chk({tag, "_afen"},  bus.af_wr_en,     1'b0);
        chk({tag, "_wden"},  bus.wdf_wr_en,    1'b0);
        chk({tag, "_addr"},  bus.af_addr_din,  31'h0);
        chk({tag, "_din"},   bus.wdf_din,      128'h0);
        chk({tag, "_mask"},  bus.wdf_mask_din, 16'hFFFF);
        chk({tag, "_cmd"},   bus.af_cmd_din,   3'b000);
    endtask

    initial begin
        int n;
        bit hit;

        rst = 1'b1;
        bus.valid = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
        bus.color = '0; bus.frame_base = '0;
        bus.af_full = 1'b0; bus.wdf_full = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst_held");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst_rel");

        // Single pixel at (3,2)
        clear_q();
        issue(10'd3, 10'd2, 10'd3, 10'd2, 24'hFF0000, 32'h0100_0000);
        wait_idle("px", n);
        chk("px_cycles", n, 3);
        chk("px_naf", af_q.size(), 1);
        chk("px_nwd", mk_q.size(), 2);
        exp_burst("px_b0", 0, 31'h0100_0800, 16'h0FFF, 16'hFFFF, px4(24'hFF0000));

        // Aligned row (8,5)-(23,5)
        clear_q();
        issue(10'd8, 10'd5, 10'd23, 10'd5, 24'h00FF00, 32'h0000_0000);
        wait_idle("row", n);
        chk("row_cycles", n, 5);
        chk("row_naf", af_q.size(), 2);
        chk("row_nwd", mk_q.size(), 4);
        exp_burst("row_b0", 0, 31'h0000_1408, 16'h0000, 16'h0000, px4(24'h00FF00));
        exp_burst("row_b1", 1, 31'h0000_1410, 16'h0000, 16'h0000, px4(24'h00FF00));

        // Swapped, clamped corners; base bit 31 and bits [19:0] ignored
        clear_q();
        issue(10'd900, 10'd650, 10'd796, 10'd598, 24'h123456, 32'hFFF0_0000);
        wait_idle("clp", n);
        chk("clp_cycles", n, 5);
        chk("clp_naf", af_q.size(), 2);
        chk("clp_nwd", mk_q.size(), 4);
        exp_burst("clp_b0", 0, 31'h7FF9_5B18, 16'hFFFF, 16'h0000, px4(24'h123456));
        exp_burst("clp_b1", 1, 31'h7FF9_5F18, 16'hFFFF, 16'h0000, px4(24'h123456));

        // Backpressure on af, then on wdf during beat B
        clear_q();
        bus.af_full = 1'b1;
        issue(10'd0, 10'd0, 10'd15, 10'd0, 24'h0F0F0F, 32'h0000_0000);
        for (int k = 0; k < 5; k++) begin
            chk("bp_af_hold_af", bus.af_wr_en, 1'b0);
            chk("bp_af_hold_wd", bus.wdf_wr_en, 1'b0);
            @(negedge clk);
        end
        bus.af_full = 1'b0;
        chk("bp_af_last", bus.af_wr_en, 1'b0);
        @(negedge clk);
        chk("bp_issue_af", bus.af_wr_en, 1'b1);
        chk("bp_issue_wd", bus.wdf_wr_en, 1'b1);
        bus.wdf_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_wd_hold", bus.wdf_wr_en, 1'b0);
        end
        bus.wdf_full = 1'b0;
        @(negedge clk);
        chk("bp_beatB", bus.wdf_wr_en, 1'b1);
        chk("bp_beatB_af", bus.af_wr_en, 1'b0);
        wait_idle("bp", n);
        chk("bp_naf", af_q.size(), 2);
        chk("bp_nwd", mk_q.size(), 4);
        exp_burst("bp_b0", 0, 31'h0000_0000, 16'h0000, 16'h0000, px4(24'h0F0F0F));
        exp_burst("bp_b1", 1, 31'h0000_0008, 16'h0000, 16'h0000, px4(24'h0F0F0F));

        // Reset during the 3rd burst of a 10x10 fill
        clear_q();
        issue(10'd0, 10'd0, 10'd9, 10'd9, 24'h00AA55, 32'h0000_0000);
        hit = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            #1;
            if (af_q.size() >= 3) hit = 1'b1;
            else @(negedge clk);
        end
        chk("mid_reached3", hit, 1'b1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("mid_rel");
        clear_q();
        issue(10'd1, 10'd1, 10'd12, 10'd1, 24'h0000FF, 32'h0030_0000);
        wait_idle("post", n);
        chk("post_cycles", n, 5);
        chk("post_naf", af_q.size(), 2);
        chk("post_nwd", mk_q.size(), 4);
        exp_burst("post_b0", 0, 31'h0030_0400, 16'h000F, 16'h0000, px4(24'h0000FF));
        exp_burst("post_b1", 1, 31'h0030_0408, 16'h0000, 16'hFFF0, px4(24'h0000FF));

        // New command while busy must be ignored
        clear_q();
        issue(10'd0, 10'd3, 10'd23, 10'd3, 24'h654321, 32'h0000_0000);
        bus.x0 = 10'd100; bus.y0 = 10'd100; bus.x1 = 10'd200; bus.y1 = 10'd200;
        bus.color = 24'hABCDEF;
        bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
        wait_idle("busy", n);
        repeat (6) @(negedge clk);
        #1;
        chk("busy_ready", bus.ready, 1'b1);
        chk("busy_naf", af_q.size(), 3);
        chk("busy_nwd", mk_q.size(), 6);
        exp_burst("busy_b0", 0, 31'h0000_0C00, 16'h0000, 16'h0000, px4(24'h654321));
        exp_burst("busy_b1", 1, 31'h0000_0C08, 16'h0000, 16'h0000, px4(24'h654321));
        exp_burst("busy_b2", 2, 31'h0000_0C10, 16'h0000, 16'h0000, px4(24'h654321));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
